// File: rtl/booth_sig_div_seq.sv
// Sequential signed divider: radix-2 restoring shift-subtract, one bit per clock.
// Optional DIV_FAST_ZERO_EN skips iteration when |dividend| < |divisor|.
module booth_sig_div_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] count;
  logic          sign_q;
  logic          sign_r;
  logic          dz;
  logic [N:0]    part;
  logic [N-1:0]  dq;
  logic [N:0]    b_mag;

  logic [N:0]    a_ext, b_ext;
  logic [N:0]    a_abs, b_abs;
  logic          zero_in;
  logic          fast;
  logic          skip;
  logic [N+1:0]  shifted;
  logic [N:0]    trial;
  logic          ge;

  assign a_ext   = {dividend[N-1], dividend};
  assign b_ext   = {divisor[N-1], divisor};
  assign a_abs   = dividend[N-1] ? -a_ext : a_ext;
  assign b_abs   = divisor[N-1] ? -b_ext : b_ext;
  assign zero_in = (divisor == '0);

`ifdef DIV_FAST_ZERO_EN
  assign fast = (a_abs < b_abs);
`else
  assign fast = 1'b0;
`endif

  assign skip = zero_in || fast;

  // trial >= 0 is the same test as shifted >= |divisor|
  assign shifted = {part, dq[N-1]};
  assign trial   = shifted[N:0] - b_mag;
  assign ge      = (shifted >= {1'b0, b_mag});

  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = skip ? FIX : CALC;
      CALC: if (count == '0) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      part        <= '0;
      dq          <= '0;
      b_mag       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count  <= CW'(N - 1);
            sign_q <= dividend[N-1] ^ divisor[N-1];
            sign_r <= dividend[N-1];
            dz     <= zero_in;
            b_mag  <= b_abs;
            // skipped cases finish with the whole dividend as remainder
            part   <= skip ? a_abs : '0;
            dq     <= skip ? '0 : a_abs[N-1:0];
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (ge) begin
            part <= trial;
            dq   <= {dq[N-2:0], 1'b1};
          end else begin
            part <= shifted[N:0];
            dq   <= {dq[N-2:0], 1'b0};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          quotient    <= dz ? '1 : (sign_q ? -dq : dq);
          remainder   <= sign_r ? -part[N-1:0] : part[N-1:0];
          // positive quotient of magnitude 2^(N-1) only from MIN / -1
          ovf         <= !dz && !sign_q && dq[N-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sig_div_seq.sv
// Scoreboard bench for booth_sig_div_seq (N=4), directed vectors.
module tb_booth_sig_div_seq;

  localparam int N = 4;

`ifdef DIV_FAST_ZERO_EN
  localparam int LTRIV = 1;
`else
  localparam int LTRIV = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         ovf;

  booth_sig_div_seq #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("ovf", ovf, e.ov);
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  // caller is at a falling edge
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] q, input logic [N-1:0] r,
                       input logic dzf, input logic ovfl, input int lat);
    exp_t x;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    x.q = q;
    x.r = r;
    x.dz = dzf;
    x.ov = ovfl;
    x.lat = lat;
    x.t0 = cyc;
    sb.push_back(x);
  endtask

  task automatic wait_done(input int exp_busy);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) n++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done expected done within 40 cycles");
    end else if (exp_busy >= 0) begin
      chk("busy_cycles", n, exp_busy);
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] q, input logic [N-1:0] r,
                     input logic dzf, input logic ovfl, input int lat);
    issue(a, b, q, r, dzf, ovfl, lat);
    wait_done(lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {quotient, remainder, busy, done, div_by_zero, ovf}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 5);
    run(4'd7, 4'hE, 4'hD, 4'd1, 1'b0, 1'b0, 5);
    run(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0, 5);
    run(4'h9, 4'hE, 4'd3, 4'hF, 1'b0, 1'b0, 5);

    run(4'h8, 4'd3, 4'hE, 4'hE, 1'b0, 1'b0, 5);
    run(4'h8, 4'hF, 4'h8, 4'd0, 1'b0, 1'b1, 5);
    run(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 5);

    run(4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1'b0, 1);
    run(4'h8, 4'd0, 4'hF, 4'h8, 1'b1, 1'b0, 1);
    run(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 5);

    // requests while busy must be dropped, not queued
    repeat (2) @(negedge clk);
    issue(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 5);
    @(negedge clk);
    @(negedge clk);
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(-1);
    run(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 5);
    repeat (6) @(negedge clk);

    // reset mid-division
    issue(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs",
        {quotient, remainder, busy, done, div_by_zero, ovf}, '0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("abort_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_idle", {busy, done}, 2'b00);
    run(4'd6, 4'hC, 4'hF, 4'd2, 1'b0, 1'b0, 5);

    run(4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 1'b0, LTRIV);
    run(4'd0, 4'hD, 4'd0, 4'd0, 1'b0, 1'b0, LTRIV);
    run(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 5);

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_sig_div_seq.md
Name: booth_sig_div_seq

Overview:
- Sequential signed integer divider, the inverse of the team's combinational Booth signed multiplier / dot-product block.
- Used wherever a product or accumulated dot product must be scaled back down, e.g. normalisation.
- Radix-2 shift-subtract on operand magnitudes, one quotient bit per clock, then sign correction.
- start/busy/done handshake; truncates toward zero.

Parameters:
N, 4, operand width in bits (two's complement); N >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  N  signed dividend, latched on accepted start
divisor  input  N  signed divisor, latched on accepted start
quotient  output  N  signed quotient, registered
remainder  output  N  signed remainder, registered
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results become valid
div_by_zero  output  1  result flag: divisor was 0
ovf  output  1  result flag: quotient not representable

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - quotient, remainder, busy, done, div_by_zero and ovf all 0.
  - Internal registers cleared.
  - Reset asserted mid-operation aborts the division; no done pulse is produced.
- States:
  - IDLE: on start=1, latch sign bits and (N+1)-bit magnitudes of both operands, load count=N-1, clear partial remainder.
    - divisor!=0: go to CALC, busy=1.
    - divisor==0: go to FIX directly, busy=1.
  - CALC, each cycle:
    - Shift {partial remainder, dividend magnitude} left 1.
    - trial = partial - |divisor|, N+1 bits.
    - trial >= 0: keep trial and shift in quotient bit 1; otherwise keep partial and shift in 0.
    - count decrements; after the count==0 iteration go to FIX.
  - FIX (one cycle):
    - Apply signs, write quotient/remainder/flags, done=1, busy=0.
    - Return to IDLE.
- Latency, edge 0 being the edge that samples start:
  - Normal: N CALC edges (1..N); outputs and done appear after edge N+1.
  - Divide by zero: outputs and done appear after edge 1.
- Handshake:
  - done is high exactly one cycle.
  - Outputs hold until the next accepted start's FIX cycle; they do not change while busy.
  - start while busy or in the FIX cycle is ignored and not queued.
  - start in the cycle after done is accepted normally.
  - Operand inputs are don't-care except on the accepting edge.
- Sign rules:
  - quotient sign = sign(dividend) XOR sign(divisor).
  - remainder sign = sign(dividend); remainder is 0 when the magnitude remainder is 0.
  - Invariant: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Width: magnitudes use N+1 bits so that -2^(N-1) is handled without loss.
- Overflow:
  - Condition: dividend = -2^(N-1) and divisor = -1.
  - quotient = -2^(N-1) (wrapped), remainder = 0, ovf = 1.
- Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero = 1, ovf = 0.
- Flags are updated in every FIX cycle, i.e. cleared by a subsequent valid division.

Optional Feature:
Macro: DIV_FAST_ZERO_EN
- Defined: in IDLE, if divisor!=0 and |dividend| < |divisor| (including dividend=0), skip CALC and go to FIX. Result is quotient=0, remainder=dividend, done after edge 1.
- Undefined: every nonzero-divisor division takes the full N+1 latency, including trivial cases. Results are identical either way; only latency differs.

Test Plan:
- N=4: 7/2, then 7/-2, then -7/2, then -7/-2 -> (q,r) = (3,1), (-3,1), (-3,-1), (3,-1); done exactly 5 cycles after start edge; busy high 5 cycles.
- N=4: -8/3 -> q=-2, r=-2; -8/-1 -> q=-8, r=0, ovf=1; next division 6/3 -> q=2, r=0, ovf=0.
- N=4: 5/0 -> q=-1 (4'hF), r=5, div_by_zero=1, done after 1 cycle; next 6/3 clears div_by_zero.
- Start 7/2; pulse start with 1/1 at cycles 2 and 4 -> second request ignored, result q=3 r=1, single done pulse; back-to-back start the cycle after done accepted.
- Start 7/2; drop rst_n at cycle 3 -> all outputs 0 immediately; no done pulse; after release, 6/-4 -> q=-1, r=2.
- 2/7 -> q=0, r=2: done after 1 cycle with DIV_FAST_ZERO_EN defined, after 5 cycles without; 0/-3 -> q=0, r=0 under the same latency rule.
